// File: rtl/unidade_controle.sv
// Stack-machine control unit: accepts one instruction at a time and sequences the
// push/pop/ALU strobes for the stack datapath while tracking occupancy and errors.
module unidade_controle #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [4:0]    instr_op,
    input  logic [DW-1:0] instr_imm,
    output logic          instr_ready,
    output logic          wren,
    output logic          controle_pilha,
    output logic          pilha_en,
    output logic          load_temp1,
    output logic          load_temp2,
    output logic [DW-1:0] din_UC,
    output logic [4:0]    opcode,
    output logic [4:0]    depth,
    output logic          done,
    output logic          erro
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP   = 3'd2,
        S_LD_T1 = 3'd3,
        S_LD_T2 = 3'd4,
        S_EXEC  = 3'd5,
        S_WB    = 3'd6,
        S_FIM   = 3'd7
    } state_t;

    localparam logic [4:0] OP_PUSH   = 5'b10000;
    localparam logic [4:0] OP_POP    = 5'b10001;
    localparam logic [4:0] OP_NOP    = 5'b11111;
    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    // ALU operations occupy the bottom eight codes (00000..00111).
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op[4:3] == 2'b00);
    endfunction

    state_t        state_q, state_d;
    logic [4:0]    depth_q, depth_d;
    logic          erro_q, erro_d;
    logic [4:0]    op_q, op_d;
    logic [DW-1:0] imm_q, imm_d;

    logic          instr_ready_q, instr_ready_d;
    logic          wren_q, wren_d;
    logic          controle_pilha_q, controle_pilha_d;
    logic          pilha_en_q, pilha_en_d;
    logic          load_temp1_q, load_temp1_d;
    logic          load_temp2_q, load_temp2_d;
    logic [DW-1:0] din_uc_q, din_uc_d;
    logic [4:0]    opcode_q, opcode_d;
    logic          done_q, done_d;

    // Next-state, occupancy and error tracking; all checks happen at acceptance.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        erro_d  = erro_q;
        op_d    = op_q;
        imm_d   = imm_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d  = instr_op;
                    imm_d = instr_imm;
                    if (is_alu_op(instr_op)) begin
                        if (depth_q < 5'd2) begin
                            erro_d  = 1'b1;
                            state_d = S_FIM;
                        end else begin
                            state_d = S_LD_T1;
                        end
                    end else if (instr_op == OP_PUSH) begin
                        if (depth_q == DEPTH_MAX) begin
                            erro_d  = 1'b1;
                            state_d = S_FIM;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end else if (instr_op == OP_POP) begin
                        if (depth_q == 5'd0) begin
                            erro_d  = 1'b1;
                            state_d = S_FIM;
                        end else begin
                            state_d = S_POP;
                        end
                    end else if (instr_op == OP_NOP) begin
                        state_d = S_FIM;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = S_FIM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUSH: begin
                depth_d = depth_q + 5'd1;
                state_d = S_FIM;
            end
            S_POP: begin
                depth_d = depth_q - 5'd1;
                state_d = S_FIM;
            end
            S_LD_T1: begin
                depth_d = depth_q - 5'd1;
                state_d = S_LD_T2;
            end
            S_LD_T2: begin
                depth_d = depth_q - 5'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                depth_d = depth_q + 5'd1;
                state_d = S_FIM;
            end
            S_FIM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every strobe leaves a flop.
    always_comb begin
        instr_ready_d    = 1'b0;
        wren_d           = 1'b0;
        controle_pilha_d = 1'b0;
        pilha_en_d       = 1'b0;
        load_temp1_d     = 1'b0;
        load_temp2_d     = 1'b0;
        din_uc_d         = '0;
        opcode_d         = 5'b00000;
        done_d           = 1'b0;
        case (state_d)
            S_IDLE: begin
                instr_ready_d = 1'b1;
            end
            S_PUSH: begin
                wren_d     = 1'b1;
                pilha_en_d = 1'b1;
                din_uc_d   = imm_d;
            end
            S_POP: begin
                pilha_en_d = 1'b1;
            end
            S_LD_T1: begin
                pilha_en_d   = 1'b1;
                load_temp1_d = 1'b1;
                opcode_d     = op_d;
            end
            S_LD_T2: begin
                pilha_en_d   = 1'b1;
                load_temp2_d = 1'b1;
                opcode_d     = op_d;
            end
            S_EXEC: begin
                opcode_d = op_d;
            end
            S_WB: begin
                wren_d           = 1'b1;
                controle_pilha_d = 1'b1;
                pilha_en_d       = 1'b1;
                opcode_d         = op_d;
            end
            S_FIM: begin
                done_d = 1'b1;
            end
            default: begin
                instr_ready_d = 1'b0;
            end
        endcase
    end

    // State, bookkeeping and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            depth_q          <= 5'd0;
            erro_q           <= 1'b0;
            op_q             <= 5'b00000;
            imm_q            <= '0;
            instr_ready_q    <= 1'b1;
            wren_q           <= 1'b0;
            controle_pilha_q <= 1'b0;
            pilha_en_q       <= 1'b0;
            load_temp1_q     <= 1'b0;
            load_temp2_q     <= 1'b0;
            din_uc_q         <= '0;
            opcode_q         <= 5'b00000;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            depth_q          <= depth_d;
            erro_q           <= erro_d;
            op_q             <= op_d;
            imm_q            <= imm_d;
            instr_ready_q    <= instr_ready_d;
            wren_q           <= wren_d;
            controle_pilha_q <= controle_pilha_d;
            pilha_en_q       <= pilha_en_d;
            load_temp1_q     <= load_temp1_d;
            load_temp2_q     <= load_temp2_d;
            din_uc_q         <= din_uc_d;
            opcode_q         <= opcode_d;
            done_q           <= done_d;
        end
    end

    assign instr_ready    = instr_ready_q;
    assign wren           = wren_q;
    assign controle_pilha = controle_pilha_q;
    assign pilha_en       = pilha_en_q;
    assign load_temp1     = load_temp1_q;
    assign load_temp2     = load_temp2_q;
    assign din_UC         = din_uc_q;
    assign opcode         = opcode_q;
    assign depth          = depth_q;
    assign done           = done_q;
    assign erro           = erro_q;

endmodule
